// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic operand front-end.
// Holds the array geometry, operand type, FSM states and the skew index helper.
package systolic_pkg;

  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int DRAIN = N;
  localparam int AW    = $clog2(N);
  localparam int CW    = $clog2(2 * N);

  localparam logic [CW-1:0] BEAT_LAST  = CW'(2 * N - 1);
  localparam logic [CW-1:0] BEAT_B0    = CW'(N);
  localparam logic [CW-1:0] STEP_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
  localparam logic [CW:0]   N_W        = (CW + 1)'(N);

  typedef logic signed [DW-1:0] operand_t;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // {hit, offset}: lane sees element (step - lane) when that lands inside 0..N-1
  function automatic logic [AW:0] skew_index(input logic [CW-1:0] step,
                                             input logic [AW-1:0] lane);
    logic [CW:0] diff;
    diff = {1'b0, step} - {{(CW + 1 - AW){1'b0}}, lane};
    skew_index = {(diff[CW] == 1'b0) && (diff < N_W), diff[AW-1:0]};
  endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// N x N operand register bank: one full-row write port, N independent element reads.
// Contents are intentionally not reset; a new load always overwrites every row.
module systolic_operand_buf
  import systolic_pkg::*;
(
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   wrow_i,
  input  logic [N*DW-1:0] wdata_i,
  input  logic [AW-1:0]   rd_row_i  [N],
  input  logic [AW-1:0]   rd_col_i  [N],
  output operand_t        rd_data_o [N]
);

  operand_t mem_q [N][N];

  // capture one row on a write beat
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < N; k++) begin
        mem_q[wrow_i][k] <= operand_t'(wdata_i[k*DW +: DW]);
      end
    end
  end

  // element read ports
  always_comb begin
    for (int p = 0; p < N; p++) begin
      rd_data_o[p] = mem_q[rd_row_i[p]][rd_col_i[p]];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads A then B row by row, then drives skewed wavefronts onto the array west/north edges
// through a clear / feed / drain / done sequence. All array-facing outputs are registered.
module systolic_skew_feeder
  import systolic_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] in_row_i,
  output logic [N*DW-1:0] a_edge_o,
  output logic [N*DW-1:0] b_edge_o,
  output logic            feed_valid_o,
  output logic            array_clear_o,
  output logic            busy_o,
  output logic            done_o
);

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            beat_s, a_we_s, b_we_s;
  logic [AW-1:0]   lane_s [N];
  logic [AW-1:0]   off_s  [N];
  logic [N-1:0]    hit_s;
  operand_t        a_rd_s [N];
  operand_t        b_rd_s [N];
  logic [N*DW-1:0] a_edge_d, a_edge_q, b_edge_d, b_edge_q;
  logic            fv_d, fv_q, clr_d, clr_q, busy_d, busy_q, done_d, done_q;

  assign in_ready_o = (state_q == ST_LOAD);
  assign beat_s     = in_valid_i & in_ready_o;
  assign a_we_s     = beat_s & (beat_q < BEAT_B0);
  assign b_we_s     = beat_s & (beat_q >= BEAT_B0);

  systolic_operand_buf u_buf_a (
    .clk       (clk),
    .we_i      (a_we_s),
    .wrow_i    (beat_q[AW-1:0]),
    .wdata_i   (in_row_i),
    .rd_row_i  (lane_s),
    .rd_col_i  (off_s),
    .rd_data_o (a_rd_s)
  );

  systolic_operand_buf u_buf_b (
    .clk       (clk),
    .we_i      (b_we_s),
    .wrow_i    (beat_q[AW-1:0]),
    .wdata_i   (in_row_i),
    .rd_row_i  (off_s),
    .rd_col_i  (lane_s),
    .rd_data_o (b_rd_s)
  );

  // sequencing: beat counter in LOAD, shared step/drain counter afterwards
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (beat_s && (beat_q == BEAT_LAST)) begin
          state_d = ST_CLEAR;
          beat_d  = {CW{1'b0}};
        end else if (beat_s) begin
          beat_d = beat_q + CW'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        cnt_d   = {CW{1'b0}};
      end
      ST_FEED: begin
        if (cnt_q == STEP_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
        beat_d  = {CW{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // edges are looked up for the step about to be presented so they register in step
  always_comb begin
    a_edge_d = {(N*DW){1'b0}};
    b_edge_d = {(N*DW){1'b0}};
    for (int p = 0; p < N; p++) begin
      lane_s[p]           = AW'(p);
      {hit_s[p], off_s[p]} = skew_index(cnt_d, AW'(p));
      a_edge_d[p*DW +: DW] = (state_d == ST_FEED && hit_s[p]) ? a_rd_s[p] : {DW{1'b0}};
      b_edge_d[p*DW +: DW] = (state_d == ST_FEED && hit_s[p]) ? b_rd_s[p] : {DW{1'b0}};
    end
    fv_d   = (state_d == ST_FEED);
    clr_d  = (state_d == ST_CLEAR);
    busy_d = (state_d != ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      beat_q   <= {CW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      a_edge_q <= {(N*DW){1'b0}};
      b_edge_q <= {(N*DW){1'b0}};
      fv_q     <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
      fv_q     <= fv_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign a_edge_o      = a_edge_q;
  assign b_edge_o      = b_edge_q;
  assign feed_valid_o  = fv_q;
  assign array_clear_o = clr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder: load, skew, latency, reset abort,
// back-to-back loads and per-run pulse counts.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_row_i = 64'd0;
  logic [63:0] a_edge_o, b_edge_o;
  logic        feed_valid_o, array_clear_o, busy_o, done_o;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int last_drv_cyc, clr_cyc, d1, d2, hs;
  int fv_tot = 0, clr_tot = 0, done_tot = 0, busy_tot = 0;

  logic [7:0]  ma [8][8];
  logic [7:0]  mb [8][8];
  logic [63:0] cap_a [15];
  logic [63:0] cap_b [15];
  logic [63:0] tbl [32];

  systolic_skew_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_row_i      (in_row_i),
    .a_edge_o      (a_edge_o),
    .b_edge_o      (b_edge_o),
    .feed_valid_o  (feed_valid_o),
    .array_clear_o (array_clear_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      fv_tot   = fv_tot + int'(feed_valid_o);
      clr_tot  = clr_tot + int'(array_clear_o);
      done_tot = done_tot + int'(done_o);
      busy_tot = busy_tot + int'(busy_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mats(input int p);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        case (p)
          0: begin ma[i][k] = 8'(i*8 + k);    mb[i][k] = (i == k) ? 8'd1 : 8'd0; end
          1: begin ma[i][k] = 8'h80;          mb[i][k] = 8'hFF;                  end
          2: begin ma[i][k] = 8'((k - i)*3);  mb[i][k] = 8'(i*k - 20);           end
          3: begin ma[i][k] = 8'(i + k + 1);  mb[i][k] = 8'(-(i*8 + k));         end
          default: begin ma[i][k] = 8'(i*k - 7); mb[i][k] = 8'(k - i);          end
        endcase
      end
    end
  endtask

  function automatic logic [63:0] row_a(input int r);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = ma[r][k];
    return v;
  endfunction

  function automatic logic [63:0] row_b(input int r);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = mb[r][k];
    return v;
  endfunction

  // a_edge[i] = A[i][t-i], b_edge[j] = B[t-j][j], zero outside the matrix
  function automatic logic [63:0] exp_a(input int t);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 8; i++) if (t - i >= 0 && t - i < 8) v[i*8 +: 8] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [63:0] exp_b(input int t);
    logic [63:0] v = 64'd0;
    for (int j = 0; j < 8; j++) if (t - j >= 0 && t - j < 8) v[j*8 +: 8] = mb[t-j][j];
    return v;
  endfunction

  task automatic load(input bit gaps, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      in_row_i   = (b < 8) ? row_a(b) : row_b(b - 8);
      check("ld_ready", {63'd0, in_ready_o}, 64'd1);
      last_drv_cyc = cyc;
      @(posedge clk);
      if (gaps && b < nbeats - 1) begin
        @(negedge clk);
        in_valid_i = 1'b0;
        in_row_i   = {$urandom, $urandom};
      end
    end
    #1 in_valid_i = 1'b0;
  endtask

  // waits for array_clear, then walks clear, 15 feed steps, drain, done and the return to LOAD
  task automatic run_check(input string nm, output int done_cyc);
    int fv0, clr0, done0, busy0;
    bit seen = 1'b0;
    #1;
    fv0 = fv_tot; clr0 = clr_tot; done0 = done_tot; busy0 = busy_tot;
    done_cyc = -1;
    for (int w = 0; w < 300 && !seen; w++) begin
      @(negedge clk);
      seen = array_clear_o;
    end
    if (!seen) begin
      check({nm, "_clear_timeout"}, 64'd0, 64'd1);
    end else begin
      clr_cyc = cyc;
      check({nm, "_clear_flags"}, {59'd0, feed_valid_o, busy_o, in_ready_o, done_o, 1'b0},
            {59'd0, 5'b01000});
      check({nm, "_clear_edges"}, a_edge_o | b_edge_o, 64'd0);
      for (int t = 0; t < 15; t++) begin
        @(negedge clk);
        cap_a[t] = a_edge_o;
        cap_b[t] = b_edge_o;
        check({nm, $sformatf("_fv_t%0d", t)},
              {59'd0, feed_valid_o, array_clear_o, in_ready_o, done_o, busy_o},
              {59'd0, 5'b10001});
        check({nm, $sformatf("_a_t%0d", t)}, a_edge_o, exp_a(t));
        check({nm, $sformatf("_b_t%0d", t)}, b_edge_o, exp_b(t));
      end
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check({nm, $sformatf("_drain%0d", k)},
              {59'd0, feed_valid_o, array_clear_o, in_ready_o, done_o, busy_o},
              {59'd0, 5'b00001});
        check({nm, $sformatf("_drain_edges%0d", k)}, a_edge_o | b_edge_o, 64'd0);
      end
      @(negedge clk);
      check({nm, "_done"}, {61'd0, done_o, busy_o, in_ready_o}, {61'd0, 3'b110});
      check({nm, "_done_lat"}, 64'(cyc - clr_cyc), 64'd24);
      done_cyc = cyc;
      @(negedge clk);
      check({nm, "_after"}, {61'd0, done_o, busy_o, in_ready_o}, {61'd0, 3'b001});
      #1;
      check({nm, "_fv_count"},   64'(fv_tot - fv0),     64'd15);
      check({nm, "_clr_count"},  64'(clr_tot - clr0),   64'd1);
      check({nm, "_done_count"}, 64'(done_tot - done0), 64'd1);
      check({nm, "_busy_count"}, 64'(busy_tot - busy0), 64'd25);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_edges", a_edge_o | b_edge_o, 64'd0);
    check("rst_flags", {59'd0, feed_valid_o, array_clear_o, busy_o, done_o, in_ready_o},
          {59'd0, 5'b00001});
    reset = 1'b0;

    // 1: ramp A, identity B, back-to-back beats
    set_mats(0);
    load(1'b0, 16);
    run_check("t1", d1);
    check("t1_clear_after_beat", 64'(clr_cyc - last_drv_cyc), 64'd1);
    check("t1_a_s0",  cap_a[0],  64'h0);
    check("t1_b_s0",  cap_b[0],  64'h01);
    check("t1_a_s7",  cap_a[7],  64'h38312A231C150E07);
    check("t1_b_s7",  cap_b[7],  64'h0);
    check("t1_a_s14", cap_a[14], 64'h3F00000000000000);
    check("t1_b_s14", cap_b[14], 64'h0100000000000000);

    // 2: same data with in_valid toggling
    load(1'b1, 16);
    run_check("t2", d1);
    check("t2_clear_after_beat", 64'(clr_cyc - last_drv_cyc), 64'd1);
    check("t2_a_s7", cap_a[7], 64'h38312A231C150E07);

    // 3: negative operands
    set_mats(1);
    load(1'b0, 16);
    run_check("t3", d1);
    check("t3_a_s0",  cap_a[0],  64'h80);
    check("t3_b_s0",  cap_b[0],  64'hFF);
    check("t3_a_s7",  cap_a[7],  64'h8080808080808080);
    check("t3_b_s7",  cap_b[7],  64'hFFFFFFFFFFFFFFFF);
    check("t3_a_s14", cap_a[14], 64'h8000000000000000);
    check("t3_b_s14", cap_b[14], 64'hFF00000000000000);

    // 4: reset at FEED step 5, then a discarded partial load, then a fresh run
    set_mats(2);
    load(1'b0, 16);
    repeat (7) @(negedge clk);
    check("t4_at_s5", a_edge_o, exp_a(5));
    reset = 1'b1;
    #1;
    check("t4_rst_edges", a_edge_o | b_edge_o, 64'd0);
    check("t4_rst_flags", {60'd0, feed_valid_o, array_clear_o, busy_o, done_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_ready", {62'd0, in_ready_o, busy_o}, {62'd0, 2'b10});
    set_mats(0);
    load(1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_mats(2);
    load(1'b0, 16);
    run_check("t4", d1);

    // 5: in_valid held high across two runs
    set_mats(4);
    for (int r = 0; r < 8; r++) begin tbl[16+r] = row_a(r); tbl[24+r] = row_b(r); end
    set_mats(3);
    for (int r = 0; r < 8; r++) begin tbl[r] = row_a(r); tbl[8+r] = row_b(r); end
    hs = 0;
    fork
      begin
        logic rdy;
        for (int c = 0; c < 400 && hs < 32; c++) begin
          @(negedge clk);
          in_valid_i = 1'b1;
          in_row_i   = tbl[hs];
          rdy        = in_ready_o;
          @(posedge clk);
          if (rdy) hs++;
        end
        #1 in_valid_i = 1'b0;
      end
      begin
        run_check("t5a", d1);
        set_mats(4);
        run_check("t5b", d2);
      end
    join
    check("t5_beats", 64'(hs), 64'd32);
    check("t5_done_gap", 64'(d2 - d1), 64'd41);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
